instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Sequential instruction encoder and loader for the single-cycle processor. It accepts decoded instruction fields over a valid/ready stream and packs each one into the 32-bit instruction word that the processor's control decode consumes. It buffers the packed words in a small FIFO and writes them to consecutive instruction-memory addresses. It sits between the test/boot program source and instruction memory, and runs before the processor is released from reset.

## Interface
- ADDR_W, 8: instruction-memory word-address width.
- DEPTH, 4: FIFO depth in words; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; begins a load session; ignored outside IDLE.
- start_addr  in  ADDR_W  first word address of the session, sampled on accepted start.
- in_valid / in_ready  in / out  1 each  instruction-field handshake; transfer when both are high at a clock edge.
- in_last  in  1  marks the final instruction of the session.
- in_opcode  in  6  instruction opcode.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  I-type immediate.
- in_target  in  26  jump target.
- imem_stall  in  1  memory cannot take a write this cycle.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  packed instruction word.
- busy  out  1  high in LOAD and FLUSH.
- done  out  1  one-cycle pulse when the session completes.
- err_illegal  out  1  one-cycle pulse on an accepted illegal opcode.
- wr_count  out  ADDR_W+1  number of words written in the current or last session.
- wrapped  out  1  sticky; the address counter wrapped during this session.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE→LOAD on start: addr←start_addr, wr_count←0, wrapped←0.
  - LOAD→FLUSH on the accepted beat with in_last=1.
  - FLUSH→DONE when the FIFO is empty and no write is in progress.
  - DONE→IDLE unconditionally after one cycle; done=1 only in DONE.
- in_ready = (state==LOAD) && FIFO not full. There is no pass-through when full.
- Packing, with opcode always in [31:26]:
  - opcode 0 (R-type): {op,rs,rt,rd,shamt,funct}.
  - opcodes 1 and 3 (j, jal): {op,target}.
  - opcode 2 (jr): {op,rs,21'b0}.
  - opcodes 4–16 (I-type: ALU-immediate, branches 5–10, sw 11, lw 12): {op,rs,rt,imm}.
  - Unused fields are ignored.
- Opcode >16 is illegal: the beat is accepted but not enqueued, and err_illegal pulses. If in_last is set on that beat, the state still moves to FLUSH.
- Drain: when the FIFO is non-empty and imem_stall=0:
  - imem_we=1 with the head word and the current addr;
  - addr increments mod 2^ADDR_W and wr_count increments;
  - a transition of addr from all-ones to 0 sets wrapped.
- The FIFO supports enqueue and dequeue in the same cycle. Occupancy is unchanged in that case.
- Reset values: state IDLE, FIFO empty, addr 0, and all outputs 0 (including in_ready, imem_we, imem_wdata, wr_count, wrapped).
- Reset asserted mid-session discards the FIFO contents. No write is issued in the reset cycle or after it.

## Timing
- imem_we, imem_addr and imem_wdata are registered.
- A word accepted at edge k appears on imem_we at cycle k+1 if the FIFO was empty and imem_stall=0. Sustained throughput is one word per cycle.
- imem_stall high in cycle c holds the head word. imem_we is 0 in cycle c and the head is retried in the next unstalled cycle.
- in_ready drops in the cycle after the FIFO reaches DEPTH entries. Backpressure is lossless.
- done is asserted in the cycle after the last write strobe, or in the cycle after the in_last beat if nothing was pending.

## Test plan
- start, start_addr=0x10; R-type op0 rs1 rt2 rd3 shamt0 funct0x20 with in_last -> imem_we at addr 0x10, wdata 0x00221820; done one cycle later; wr_count=1.
- Back-to-back j target 0x10, jr rs31, lw rs29 rt8 imm4 (in_last) -> writes 0x04000010, 0x0BE00000, 0x33A80004 on consecutive cycles at addrs 0,1,2.
- imem_stall held high for 8 cycles while 6 beats are offered, DEPTH=4 -> in_ready low after 4 accepts; after the stall releases, all 6 words are written in order with no loss or duplication.
- Opcode 20 between two valid beats -> err_illegal pulses once; only 2 words written; addresses contiguous.
- start_addr=0xFE with 3 words -> addrs 0xFE, 0xFF, 0x00; wrapped=1.
- rst_n low during FLUSH with 3 words queued -> no further imem_we; all outputs 0; start after reset begins a clean session.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 32-bit words, buffers them in a small FIFO
// and writes them to consecutive instruction-memory addresses.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting instruction beats and draining the FIFO
// FLUSH | last beat seen, draining remaining FIFO words
// DONE  | one-cycle completion pulse
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              imem_stall,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [ADDR_W:0]   wr_count,
  output logic              wrapped
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       packed_word;
  logic              fifo_full, fifo_empty, legal, accept, enq, deq;

  assign fifo_full  = (count == (PW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign legal      = (in_opcode <= 6'd16);
  assign in_ready   = (state == LOAD) && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign enq        = accept && legal;
  assign deq        = !fifo_empty && !imem_stall;
  assign busy       = (state == LOAD) || (state == FLUSH);
  assign done       = (state == DONE);

  always_comb begin
    packed_word = {in_opcode, 26'b0};
    case (in_opcode)
      6'd0:        packed_word = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
      6'd1, 6'd3:  packed_word = {in_opcode, in_target};
      6'd2:        packed_word = {in_opcode, in_rs, 21'b0};
      default:     packed_word = {in_opcode, in_rs, in_rt, in_imm};
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && in_last) state_nxt = FLUSH;
      FLUSH:   if (fifo_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage array carries no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= packed_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      addr        <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      err_illegal <= 1'b0;
      wr_count    <= '0;
      wrapped     <= 1'b0;
    end else begin
      state       <= state_nxt;
      imem_we     <= deq;
      err_illegal <= accept && !legal;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (deq) begin
        imem_addr  <= addr;
        imem_wdata <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
        addr       <= addr + 1'b1;
        wr_count   <= wr_count + 1'b1;
        if (&addr) wrapped <= 1'b1;
      end
      if (state == IDLE && start) begin
        addr     <= start_addr;
        wr_count <= '0;
        wrapped  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, in_last, imem_stall;
  logic [7:0]  start_addr, imem_addr;
  logic [5:0]  in_opcode, in_funct;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        imem_we, busy, done, err_illegal, wrapped;
  logic [31:0] imem_wdata;
  logic [8:0]  wr_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, acc_cnt = 0, done_cyc = 0;
  logic [7:0]  wa [$];
  logic [31:0] wd [$];
  int          wc [$];
  int w0, d0, e0, a0;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .imem_stall(imem_stall), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .err_illegal(err_illegal), .wr_count(wr_count), .wrapped(wrapped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (err_illegal) err_cnt <= err_cnt + 1;
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    w0 = wa.size(); d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
  endtask

  task automatic do_start(input logic [7:0] a);
    start = 1'b1; start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    int n = 0;
    in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (in_ready) break;
    end
    if (n >= 200) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("done_seen", 32'(done_cnt != d0), 1);
    @(posedge clk); #2;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_funct = '0; in_imm = '0; in_target = '0; imem_stall = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_we", 32'(imem_we), 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_wrapped", 32'(wrapped), 0);
    check("rst_busy", 32'(busy), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // single R-type
    snap();
    do_start(8'h10);
    send(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1);
    wait_done();
    check("t1_nwr", wa.size() - w0, 1);
    check("t1_addr", 32'(wa[w0]), 32'h10);
    check("t1_data", wd[w0], 32'h00221820);
    check("t1_done_lat", done_cyc - wc[w0], 1);
    check("t1_wr_count", 32'(wr_count), 1);

    // j / jr / lw back to back
    snap();
    do_start(8'h00);
    send(6'd1, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10, 1'b0);
    send(6'd2, 5'd31, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0, 1'b0);
    send(6'd12, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h4, 26'h0, 1'b1);
    wait_done();
    check("t2_nwr", wa.size() - w0, 3);
    check("t2_d0", wd[w0], 32'h04000010);
    check("t2_d1", wd[w0+1], 32'h0BE00000);
    check("t2_d2", wd[w0+2], 32'h33A80004);
    check("t2_a2", 32'(wa[w0+2]), 32'h02);
    check("t2_consec", wc[w0+2] - wc[w0], 2);

    // stall with backpressure
    snap();
    imem_stall = 1'b1;
    do_start(8'h00);
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(6'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'(i), 26'h0, i == 6);
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        check("t3_acc_full", acc_cnt - a0, 4);
        check("t3_ready_low", 32'(in_ready), 0);
        check("t3_no_wr", wa.size() - w0, 0);
        repeat (2) @(posedge clk);
        #1 imem_stall = 1'b0;
      end
    join
    wait_done();
    check("t3_nwr", wa.size() - w0, 6);
    for (int i = 0; i < 6; i++) begin
      check("t3_data", wd[w0+i], 32'h10000001 + 32'(i));
      check("t3_addr", 32'(wa[w0+i]), 32'(i));
    end
    check("t3_wr_count", 32'(wr_count), 6);

    // illegal opcode in the middle
    snap();
    do_start(8'h20);
    send(6'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'hAAAA, 26'h0, 1'b0);
    send(6'd20, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0, 1'b0);
    send(6'd12, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0055, 26'h0, 1'b1);
    wait_done();
    check("t4_err", err_cnt - e0, 1);
    check("t4_nwr", wa.size() - w0, 2);
    check("t4_a0", 32'(wa[w0]), 32'h20);
    check("t4_a1", 32'(wa[w0+1]), 32'h21);
    check("t4_d0", wd[w0], 32'h1000AAAA);
    check("t4_d1", wd[w0+1], 32'h30220055);
    check("t4_wr_count", 32'(wr_count), 2);

    // address wrap
    snap();
    do_start(8'hFE);
    for (int i = 1; i <= 3; i++)
      send(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'(i), 16'h0, 26'h0, i == 3);
    wait_done();
    check("t5_nwr", wa.size() - w0, 3);
    check("t5_a0", 32'(wa[w0]), 32'hFE);
    check("t5_a1", 32'(wa[w0+1]), 32'hFF);
    check("t5_a2", 32'(wa[w0+2]), 32'h00);
    check("t5_d2", wd[w0+2], 32'h00000003);
    check("t5_wrapped", 32'(wrapped), 1);

    // reset during FLUSH
    snap();
    imem_stall = 1'b1;
    do_start(8'h30);
    for (int i = 1; i <= 3; i++)
      send(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'(i), 16'h0, 26'h0, i == 3);
    #1;
    check("t6_busy_flush", 32'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #2;
    check("t6_we", 32'(imem_we), 0);
    check("t6_wdata", imem_wdata, 0);
    check("t6_wr_count", 32'(wr_count), 0);
    check("t6_wrapped", 32'(wrapped), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_ready", 32'(in_ready), 0);
    rst_n = 1'b1; imem_stall = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("t6_no_wr", wa.size() - w0, 0);
    check("t6_idle", 32'(busy), 0);
    @(posedge clk); #1;
    snap();
    do_start(8'h40);
    send(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1);
    wait_done();
    check("t6_nwr_clean", wa.size() - w0, 1);
    check("t6_addr_clean", 32'(wa[w0]), 32'h40);
    check("t6_data_clean", wd[w0], 32'h00221820);
    check("t6_wrc_clean", 32'(wr_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
